// File: rtl/alu_share_arb_if.sv
// rtl/alu_share_arb_if.sv - requester, ALU and response signals of the shared-ALU arbiter
interface alu_share_arb_if #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int OPW  = 2
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic [NREQ*OPW-1:0] req_op;
    logic [NREQ-1:0]     req_ready;
    logic [W-1:0]        alu_a;
    logic [W-1:0]        alu_b;
    logic [OPW-1:0]      alu_type;
    logic [W-1:0]        alu_c;
    logic [NREQ-1:0]     rsp_valid;
    logic [W-1:0]        rsp_data;
    logic                busy;

    // master is the environment: requesters plus the ALU instance
    modport master (
        output req_valid, req_a, req_b, req_op, alu_c,
        input  req_ready, alu_a, alu_b, alu_type, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_c,
        output req_ready, alu_a, alu_b, alu_type, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin arbiter time-sharing one ALU among NREQ requesters
module alu_share_arb #(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int OPW     = 2,
    parameter int ALU_LAT = 0
) (
    input  logic clk,
    input  logic rst,
    alu_share_arb_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] grant_idx;
    logic          grant_found;
    logic          accept;
    logic [CW-1:0] cnt;

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = (32'(base) + off) % NREQ;
        return PW'(s);
    endfunction

    // first valid requester at or after ptr, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && bus.req_valid[wrap_idx(ptr, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(ptr, k);
            end
        end
    end

    assign accept        = grant_found && (state != WAIT) && !rst;
    assign bus.req_ready = accept ? (NREQ'(1) << grant_idx) : '0;
    assign bus.busy      = (state == WAIT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = accept ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            owner         <= '0;
            cnt           <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_type  <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_valid <= '0;
        end else begin
            state         <= state_nxt;
            bus.rsp_valid <= '0;
            if (accept) begin
                bus.alu_a    <= bus.req_a[grant_idx*W +: W];
                bus.alu_b    <= bus.req_b[grant_idx*W +: W];
                bus.alu_type <= bus.req_op[grant_idx*OPW +: OPW];
                owner        <= grant_idx;
                ptr          <= wrap_idx(grant_idx, 1);
                cnt          <= CW'(ALU_LAT);
            end else if (state == WAIT) begin
                // operands stay put; alu_c is sampled on the last WAIT cycle
                if (cnt == '0) begin
                    bus.rsp_data  <= bus.alu_c;
                    bus.rsp_valid <= NREQ'(1) << owner;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and sequencer that time-shares one ALU datapath (operands `a`, `b`, `type`; result `c`) among `NREQ` requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALU operand registers. It waits a configurable number of cycles for the ALU result, then returns the captured result to the winning requester with a one-hot response strobe. It sits between the requester blocks and the single ALU instance; the ALU itself, including its VPI-modelled variant, is outside this block.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `W`, 32: operand/result width.
- `OPW`, 2: width of the operation-type field (opaque to this block).
- `ALU_LAT`, 0: cycles between operands appearing on `alu_*` and `alu_c` being valid (0 = combinational ALU).
- `clk`  in  1  clock; reset `rst`, synchronous, active-high.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_a`, `req_b`  in  NREQ*W  packed operands; requester i uses bits [i*W +: W].
- `req_op`  in  NREQ*OPW  packed operation type.
- `req_ready`  out  NREQ  one-hot grant/accept; at most one bit set.
- `alu_a`, `alu_b`  out  W  registered ALU operands.
- `alu_type`  out  OPW  registered ALU operation.
- `alu_c`  in  W  ALU result.
- `rsp_valid`  out  NREQ  one-hot, single-cycle response strobe.
- `rsp_data`  out  W  captured result; valid while any `rsp_valid` bit is set.
- `busy`  out  1  high in WAIT.

## Operation
- FSM states:
  - IDLE: no operation in flight.
  - WAIT: operation issued to the ALU, counter `cnt` running.
  - RESP: `rsp_valid` asserted for the completed operation.
- Arbitration:
  - Runs combinationally in IDLE and RESP only.
  - Winner g is the first i with `req_valid[i]`, scanning from `ptr` upward mod NREQ.
  - `req_ready[g]`=1; all other bits are 0. `req_ready` is all-zero in WAIT and while `rst` is high.
- Accept happens at a clock edge where `req_valid[g] & req_ready[g]`. On accept:
  - `alu_a`/`alu_b`/`alu_type` are loaded from slice g.
  - `owner`=g, `ptr`=(g+1) mod NREQ, `cnt`=ALU_LAT, next state WAIT.
- WAIT:
  - If `cnt`==0: capture `alu_c` into `rsp_data`, set `rsp_valid`=1<<owner, go to RESP.
  - Otherwise decrement `cnt`.
  - `alu_*` are held stable throughout.
- RESP:
  - `rsp_valid` is high for exactly this cycle.
  - If an accept occurs at this edge, go to WAIT (back-to-back). Otherwise go to IDLE.
  - `rsp_valid` clears at the next edge in either case.
- Requester rule: once `req_valid[i]` rises, it and its operands must hold until accepted. The arbiter does not buffer requests.
- Results pass through unmodified; width wrap-around is ALU behaviour. `alu_type` is forwarded without decoding.
- Reset (any state, including mid-WAIT):
  - State returns to IDLE and `ptr`=0.
  - `alu_a`=`alu_b`=0, `alu_type`=0, `rsp_data`=0, `rsp_valid`=0, `busy`=0.
  - An in-flight operation is dropped with no response.

## Timing
- Accept at edge T, which ends cycle T:
  - WAIT occupies cycles T+1 .. T+1+ALU_LAT.
  - `rsp_valid` is high in cycle T+2+ALU_LAT.
- Request-to-response latency is ALU_LAT+2 cycles.
- Peak throughput is one operation per ALU_LAT+2 cycles, because accept is allowed during RESP.
- `req_ready` may be high in the same cycle `req_valid` first rises, i.e. zero-wait grant in IDLE/RESP.
- Simultaneous requests: exactly one grant per accept opportunity, in round-robin order. Worst-case wait for a persistent requester is (NREQ-1)*(ALU_LAT+2) cycles.
- First cycle after `rst` deasserts: IDLE, and a grant is possible.

## Test plan
- Single request, adding ALU, ALU_LAT=0: requester 0, a=3, b=5, op=0 accepted at edge T -> `rsp_valid`=4'b0001 and `rsp_data`=8 in cycle T+2, `busy` high in T+1 only.
- All four `req_valid` held high after reset, each requester refilling immediately -> accept order 0,1,2,3,0,1, one accept every 2 cycles, `rsp_valid` one-hot in the same order.
- ALU_LAT=2, requesters 1 and 3 both pending -> grants 1 then 3 spaced 4 cycles apart. `alu_a/b/type` stable across each WAIT. Each response carries the owner's result.
- Only requester 2 valid, after a grant to requester 3 -> grant wraps to 2 (`ptr` 0 scanned to 2). Subsequent back-to-back requests from 2 alone are granted every ALU_LAT+2 cycles.
- Operands a=32'hFFFF_FFFF, b=1, add -> `rsp_data`=0; the result is passed through unmodified.
- Reset asserted in a WAIT cycle with ALU_LAT=3 -> no `rsp_valid` for that operation. All outputs are 0 next cycle, `ptr`=0, so requester 0 wins the next contested grant.
